// File: rtl/barrel_shift_sequencer_pkg.sv
// barrel_pkg: shared constants, request record and bit-reversal helper for the
// barrel-shifter request sequencer.
// Optional feature macro: SHIFT_LEFT_EN (adds a per-request direction bit).
package barrel_pkg;

    localparam int DATA_W = 8;  // fixed by the external shifter
    localparam int AMT_W  = 3;  // log2(DATA_W)

    // One queued shift request. The direction bit exists only when left
    // shifts are enabled, so right-only builds store no extra state.
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [AMT_W-1:0]  amt;
`ifdef SHIFT_LEFT_EN
        logic              dir;
`endif
    } shift_req_t;

    // Mirror the bit order of an operand (bit 0 <-> bit DATA_W-1).
    function automatic logic [DATA_W-1:0] bitrev(input logic [DATA_W-1:0] v);
        logic [DATA_W-1:0] r;
        for (int i = 0; i < DATA_W; i++) begin
            r[i] = v[DATA_W-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/barrel_shift_sequencer_if.sv
// Request (s_*) and result (m_*) valid/ready channels of the sequencer.
// slave = sequencer side, master = requester/consumer side.
interface barrel_shift_sequencer_if ();
    import barrel_pkg::*;

    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;
    logic [AMT_W-1:0]  s_amt;
    logic              s_dir;
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;

    modport slave (
        input  s_valid, s_data, s_amt, s_dir, m_ready,
        output s_ready, m_valid, m_data
    );

    modport master (
        output s_valid, s_data, s_amt, s_dir, m_ready,
        input  s_ready, m_valid, m_data
    );

endinterface

// File: rtl/barrel_shift_sequencer_fifo.sv
// shift_req_fifo: synchronous FIFO of shift requests with occupancy count.
// Head entry is visible combinationally; DEPTH must be a power of two >= 2 so
// the pointers wrap naturally.
module shift_req_fifo
    import barrel_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  shift_req_t             wdata_i,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] level_o,
    output shift_req_t             head_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    shift_req_t       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             do_push, do_pop;

    assign full_o  = (level_q == LVL_W'(DEPTH));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign head_o  = mem_q[rd_ptr_q];

    // Full refuses pushes even when a pop happens in the same cycle.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Next-state for pointers and occupancy.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    // Pointer and occupancy registers; reset empties the queue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Entry storage write port.
    // NOTE: storage is deliberately not reset; the pointers and level alone say which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/barrel_shift_sequencer.sv
// barrel_shift_sequencer: queues shift requests, drives the external
// combinational right shifter from the queue head and registers its result
// behind a valid/ready output stage.
// Optional feature macro: SHIFT_LEFT_EN (per-request left shift via bit reversal
// around the right shifter).
module barrel_shift_sequencer
    import barrel_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    barrel_shift_sequencer_if.slave  bus,
    output logic [DATA_W-1:0]        shf_in,
    output logic [AMT_W-1:0]         shf_ctrl,
    input  logic [DATA_W-1:0]        shf_out,
    output logic [$clog2(DEPTH):0]   level
);

    shift_req_t        wr_req;
    shift_req_t        head;
    logic              full, empty, push, pop;
    logic [DATA_W-1:0] result;
    logic              m_valid_q, m_valid_d;
    logic [DATA_W-1:0] m_data_q, m_data_d;

    // Pack the incoming request; direction is kept only when left shifts exist.
    always_comb begin
        wr_req      = '0;
        wr_req.data = bus.s_data;
        wr_req.amt  = bus.s_amt;
`ifdef SHIFT_LEFT_EN
        wr_req.dir  = bus.s_dir;
`endif
    end

    // Ready is held low for the whole reset, not just the edge after it.
    assign bus.s_ready = !full && !rst;
    assign push        = bus.s_valid && bus.s_ready;
    // Advance the head whenever the result register is free or being drained.
    assign pop         = !empty && (!m_valid_q || bus.m_ready);

    shift_req_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (wr_req),
        .full_o  (full),
        .empty_o (empty),
        .level_o (level),
        .head_o  (head)
    );

    // Shifter hook-up: drive from the head (zero when empty) and undo any input reversal.
    always_comb begin
        shf_in   = '0;
        shf_ctrl = '0;
        result   = shf_out;
        if (!empty) begin
`ifdef SHIFT_LEFT_EN
            shf_in = head.dir ? bitrev(head.data) : head.data;
            result = head.dir ? bitrev(shf_out) : shf_out;
`else
            shf_in = head.data;
`endif
            shf_ctrl = head.amt;
        end
    end

    // Result register next-state: capture on pop, clear on drain, otherwise hold.
    always_comb begin
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        if (pop) begin
            m_valid_d = 1'b1;
            m_data_d  = result;
        end else if (bus.m_ready) begin
            m_valid_d = 1'b0;
        end
    end

    // Result register; reset discards any held result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
        end else begin
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
        end
    end

    assign bus.m_valid = m_valid_q;
    assign bus.m_data  = m_data_q;

endmodule
